// File: rtl/exec_alu_if.sv
// Decode-to-execute-to-memory handshake bundle for the Y86-64 execute stage.
// The stage connects through the slave modport; the upstream/downstream model uses master.
interface exec_alu_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] valE;
  logic         cnd;
  logic [2:0]   cc;
  logic         out_err;

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, out_ready,
    input  in_ready, out_valid, valE, cnd, cc, out_err
  );

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, out_ready,
    output in_ready, out_valid, valE, cnd, cc, out_err
  );
endinterface

// File: rtl/exec_alu_stage.sv
// Registered Y86-64 execute stage: operand selection, 64-bit ALU, ZF/SF/OF register
// and jXX/cmovXX condition evaluation, with valid/ready on both sides.
module exec_alu_stage #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  exec_alu_if.slave bus
);

  localparam logic [W-1:0] STEP = W'(STACK_STEP);

  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  // cc is packed {ZF,SF,OF}
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] c);
    logic zf;
    logic sf;
    logic of;
    {zf, sf, of} = c;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return (sf ^ of) | zf;
      4'd2:    return sf ^ of;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !(sf ^ of);
      4'd6:    return !(sf ^ of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Returns {OF, result}; signed overflow follows two's-complement add/sub rules.
  function automatic logic [W:0] alu_eval(input logic [1:0] fn,
                                          input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
    logic signed [W-1:0] t;
    logic                of;
    of = 1'b0;
    case (fn)
      2'd0: begin
        t  = b + a;
        of = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
      end
      2'd1: begin
        t  = b - a;
        of = (a[W-1] != b[W-1]) && (t[W-1] != b[W-1]);
      end
      2'd2:    t = b & a;
      default: t = b ^ a;
    endcase
    return {of, t};
  endfunction

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] valE_q, valE_d;
  logic         cnd_q, cnd_d;
  logic [2:0]   cc_q, cc_d;
  logic         err_q, err_d;
  logic         in_ready;
  logic         accept;
  logic [W:0]   alu_res;

  always_comb begin
    in_ready    = !out_valid_q || bus.out_ready;
    accept      = bus.in_valid && in_ready;
    alu_res     = alu_eval(bus.ifun[1:0], bus.valA, bus.valB);
    out_valid_d = out_valid_q;
    valE_d      = valE_q;
    cnd_d       = cnd_q;
    cc_d        = cc_q;
    err_d       = err_q;

    if (accept) begin
      out_valid_d = 1'b1;
      valE_d      = '0;
      cnd_d       = 1'b0;
      err_d       = 1'b0;
      case (bus.icode)
        I_OPQ: begin
          if (bus.ifun > 4'd3) begin
            err_d = 1'b1;
          end else begin
            valE_d = alu_res[W-1:0];
            cc_d   = {alu_res[W-1:0] == '0, alu_res[W-1], alu_res[W]};
          end
        end
        // cmov still forwards valA; cnd tells memory/writeback whether to commit it
        I_RRMOV: begin
          valE_d = bus.valA;
          cnd_d  = cond_eval(bus.ifun, cc_q);
          err_d  = bus.ifun > 4'd6;
        end
        I_JXX: begin
          cnd_d = cond_eval(bus.ifun, cc_q);
          err_d = bus.ifun > 4'd6;
        end
        I_IRMOV:         valE_d = bus.valC;
        I_RMMOV, I_MRMOV: valE_d = bus.valB + bus.valC;
        I_CALL, I_PUSH:  valE_d = bus.valB - STEP;
        I_RET, I_POP:    valE_d = bus.valB + STEP;
        default:         valE_d = '0;
      endcase
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      valE_q      <= '0;
      cnd_q       <= 1'b0;
      cc_q        <= 3'b100;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      valE_q      <= valE_d;
      cnd_q       <= cnd_d;
      cc_q        <= cc_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.valE      = valE_q;
  assign bus.cnd       = cnd_q;
  assign bus.cc        = cc_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_exec_alu_stage.sv
// Bench for exec_alu_stage: table of instructions with hand-derived results fed through
// a scoreboard, plus reset, back-pressure and mid-transfer reset sequences.
module tb_exec_alu_stage;
  localparam int W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  exec_alu_if #(.W(W)) bus ();

  exec_alu_stage #(.W(W), .STACK_STEP(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] e_val;
    logic         e_cnd;
    logic [2:0]   e_cc;
    logic         e_err;
  } vec_t;

  typedef struct packed {
    logic [15:0]  id;
    logic [W-1:0] val;
    logic         cnd;
    logic [2:0]   cc;
    logic         err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] c, input logic [W-1:0] e_val,
                              input logic e_cnd, input logic [2:0] e_cc, input logic e_err);
    vec_t v;
    v.icode = icode; v.ifun = ifun; v.a = a; v.b = b; v.c = c;
    v.e_val = e_val; v.e_cnd = e_cnd; v.e_cc = e_cc; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Scoreboard: compare every result the memory side takes.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got valE=%h with nothing pending", bus.valE);
      end else begin
        e = sb.pop_front();
        if ({bus.valE, bus.cnd, bus.cc, bus.out_err} !== {e.val, e.cnd, e.cc, e.err}) begin
          n_fail++;
          $display("FAIL result_%0d: got valE=%h cnd=%b cc=%b err=%b, expected valE=%h cnd=%b cc=%b err=%b",
                   e.id, bus.valE, bus.cnd, bus.cc, bus.out_err, e.val, e.cnd, e.cc, e.err);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.icode = v.icode; bus.ifun = v.ifun;
    bus.valA  = v.a;     bus.valB = v.b;   bus.valC = v.c;
  endtask

  function automatic exp_t to_exp(input vec_t v, input logic [15:0] id);
    exp_t e;
    e.id = id; e.val = v.e_val; e.cnd = v.e_cnd; e.cc = v.e_cc; e.err = v.e_err;
    return e;
  endfunction

  task automatic send(input vec_t v, input logic [15:0] id);
    int guard;
    guard = 0;
    drive(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout_%0d: in_ready=%b, expected 1", id, bus.in_ready);
    end else begin
      sb.push_back(to_exp(v, id));
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 64'(sb.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  localparam logic [W-1:0] MSB  = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t bp1, bp2, mr1;

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.icode = '0; bus.ifun = '0; bus.valA = '0; bus.valB = '0; bus.valC = '0;

    //            icode  ifun  valA        valB        valC       valE             cnd   cc     err
    tbl.push_back(mk(4'h6, 4'h2, 64'h26,     64'h31,     64'h0,     64'h20,          1'b0, 3'b000, 1'b0));
    tbl.push_back(mk(4'h6, 4'h2, 64'h0E,     64'h28,     64'h0,     64'h08,          1'b0, 3'b000, 1'b0));
    tbl.push_back(mk(4'h6, 4'h1, 64'h1,      MSB,        64'h0,     MAXP,            1'b0, 3'b001, 1'b0));
    tbl.push_back(mk(4'h7, 4'h2, 64'h0,      64'h0,      64'h40,    64'h0,           1'b1, 3'b001, 1'b0));
    tbl.push_back(mk(4'h6, 4'h0, MAXP,       64'h1,      64'h0,     MSB,             1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h7, 4'h6, 64'h0,      64'h0,      64'h0,     64'h0,           1'b1, 3'b011, 1'b0));
    tbl.push_back(mk(4'h7, 4'h1, 64'h0,      64'h0,      64'h0,     64'h0,           1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h8, 4'h0, 64'h0,      64'h200,    64'h0,     64'h1F8,         1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'hA, 4'h0, 64'h7,      64'h100,    64'h0,     64'hF8,          1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'hB, 4'h0, 64'h7,      64'h100,    64'h0,     64'h108,         1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h5, 4'h0, 64'h0,      64'h10,     64'h8,     64'h18,          1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h9, 4'h0, 64'h0,      64'h0,      64'h0,     64'h8,           1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h4, 4'h0, 64'h0,      ONES,       64'h2,     64'h1,           1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h3, 4'h0, 64'h5,      64'h9,      64'hDEAD,  64'hDEAD,        1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h0, 4'h0, 64'h5,      64'h9,      64'h3,     64'h0,           1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'hC, 4'h0, 64'h5,      64'h9,      64'h3,     64'h0,           1'b0, 3'b011, 1'b0));
    tbl.push_back(mk(4'h6, 4'h3, 64'h55,     64'h55,     64'h0,     64'h0,           1'b0, 3'b100, 1'b0));
    tbl.push_back(mk(4'h6, 4'h7, 64'h1,      64'h2,      64'h0,     64'h0,           1'b0, 3'b100, 1'b1));
    tbl.push_back(mk(4'h2, 4'h3, 64'h5,      64'h0,      64'h0,     64'h5,           1'b1, 3'b100, 1'b0));
    tbl.push_back(mk(4'h2, 4'h4, 64'h9,      64'h0,      64'h0,     64'h9,           1'b0, 3'b100, 1'b0));
    tbl.push_back(mk(4'h7, 4'h7, 64'h0,      64'h0,      64'h0,     64'h0,           1'b0, 3'b100, 1'b1));
    tbl.push_back(mk(4'h7, 4'h0, 64'h0,      64'h0,      64'h0,     64'h0,           1'b1, 3'b100, 1'b0));
    tbl.push_back(mk(4'h2, 4'h5, 64'h3,      64'h0,      64'h0,     64'h3,           1'b1, 3'b100, 1'b0));
    tbl.push_back(mk(4'h6, 4'h1, 64'h5,      64'h5,      64'h0,     64'h0,           1'b0, 3'b100, 1'b0));
    tbl.push_back(mk(4'h6, 4'h1, 64'h5,      64'h3,      64'h0,     ONES - 64'h1,    1'b0, 3'b010, 1'b0));
    tbl.push_back(mk(4'h7, 4'h2, 64'h0,      64'h0,      64'h0,     64'h0,           1'b1, 3'b010, 1'b0));
    tbl.push_back(mk(4'h6, 4'h2, MSB,        ONES,       64'h0,     MSB,             1'b0, 3'b010, 1'b0));
    tbl.push_back(mk(4'h7, 4'h1, 64'h0,      64'h0,      64'h0,     64'h0,           1'b1, 3'b010, 1'b0));

    // Asynchronous reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_valE",      bus.valE,           64'h0);
    check("rst_cc",        64'(bus.cc),        64'(3'b100));
    check("rst_cnd",       64'(bus.cnd),       64'(0));
    check("rst_err",       64'(bus.out_err),   64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) send(tbl[i], 16'(i));
    wait_drain();

    // Back-pressure: second OPq must stall and first result must hold
    bp1 = mk(4'h6, 4'h0, 64'h1, 64'h2,  64'h0, 64'h3, 1'b0, 3'b000, 1'b0);
    bp2 = mk(4'h6, 4'h1, 64'h1, 64'h10, 64'h0, 64'hF, 1'b0, 3'b000, 1'b0);
    bus.out_ready = 1'b0;
    send(bp1, 16'd100);
    drive(bp2);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  64'(bus.in_ready),  64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_valE_hold", bus.valE,           64'h3);
      check("bp_cc_hold",   64'(bus.cc),        64'(3'b000));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    sb.push_back(to_exp(bp2, 16'd101));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_drain();

    // Reset while a result is held on the output
    mr1 = mk(4'h6, 4'h1, 64'h5, 64'h3, 64'h0, ONES - 64'h1, 1'b0, 3'b010, 1'b0);
    bus.out_ready = 1'b0;
    send(mr1, 16'd200);
    check("mr_held_valid", 64'(bus.out_valid), 64'(1));
    check("mr_held_cc",    64'(bus.cc),        64'(3'b010));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(bus.out_valid), 64'(0));
    check("mr_valE",      bus.valE,           64'h0);
    check("mr_cc",        64'(bus.cc),        64'(3'b100));
    sb.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(mk(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 3'b100, 1'b0), 16'd201);
    send(mk(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 3'b100, 1'b0), 16'd202);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_alu_stage.md
Name: exec_alu_stage

Overview:
- Registered Y86-64 execute stage that consumes the 64-bit ALU operations (add, sub, and, xor).
- Selects ALU operands per icode, computes valE, and maintains the ZF/SF/OF condition-code register.
- Evaluates the branch/cmov condition and presents the result to the memory stage.
- Sits between decode (producer) and memory (consumer), with valid/ready handshakes on both sides.

Parameters:
W, 64, datapath width of valA/valB/valC/valE
STACK_STEP, 8, byte adjustment applied to %rsp for push/pop/call/ret

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
icode  input  4  Y86 instruction code
ifun  input  4  function code
valA  input  W  register operand A
valB  input  W  register operand B
valC  input  W  immediate/displacement
out_valid  output  1  registered result valid
out_ready  input  1  memory stage accepts result
valE  output  W  execute result
cnd  output  1  condition outcome for jXX/cmovXX
cc  output  3  {ZF,SF,OF} current condition codes
out_err  output  1  illegal OPq ifun (>3) seen on this result

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, valE=0, cnd=0, out_err=0.
  - cc={ZF=1,SF=0,OF=0}.
  - Takes effect immediately, mid-transfer included; any held result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Result is registered; latency is 1 cycle from accept to out_valid=1.
  - Output holds stable while out_valid && !out_ready.
  - Accept and drain in the same cycle gives back-to-back throughput of 1 instruction per cycle.
  - No accept + drain: out_valid falls to 0 next cycle.
- Operand/function selection at accept:
  - icode 6 OPq: aluA=valA, aluB=valB; ifun 0: B+A, 1: B-A, 2: B&A, 3: B^A.
  - icode 2 rrmovq/cmovXX: valE=valA.
  - icode 3 irmovq: valE=valC.
  - icode 4/5 rmmovq/mrmovq: valE=valB+valC.
  - icode 8/A call/pushq: valE=valB-STACK_STEP.
  - icode 9/B ret/popq: valE=valB+STACK_STEP.
  - All others (halt, nop, jXX, undefined): valE=0.
  - All arithmetic is modulo 2^W, with no carry out.
- Condition codes:
  - Written only when an OPq with ifun 0..3 is accepted.
  - ZF = (t==0).
  - SF = t[W-1].
  - OF:
    - add: A[W-1]==B[W-1] && t[W-1]!=A[W-1].
    - sub: A[W-1]!=B[W-1] && t[W-1]!=B[W-1].
    - and/xor: 0.
  - OPq with ifun>3: valE=0, out_err=1, cc unchanged.
- cnd:
  - Registered at accept for icode 2 and 7; 0 for all other icodes.
  - Evaluated from cc as held before the accepting edge.
  - ifun 0: 1; 1 le: (SF^OF)|ZF; 2 l: SF^OF; 3 e: ZF; 4 ne: !ZF; 5 ge: !(SF^OF); 6 g: !(SF^OF)&!ZF.
  - ifun>6 gives cnd=0 and out_err=1.
  - An OPq accepted on cycle N affects cnd only for instructions accepted on cycle N+1 or later.
- Stall: when in_valid is held while in_ready=0, nothing is latched and cc is not updated.

Test Plan:
- Reset: pulse rst_n low asynchronously mid-cycle -> out_valid=0, valE=0, cc=3'b100 immediately.
- OPq and: ifun 2, valA=64'h26, valB=64'h31 -> one cycle later valE=64'h20, cc=3'b000. Then valA=64'h0E, valB=64'h28 -> valE=64'h08.
- Sub overflow: ifun 1, valB=64'h8000_0000_0000_0000, valA=1 -> valE=64'h7FFF_FFFF_FFFF_FFFF, cc=3'b001. Next jXX ifun 2 (l) -> cnd=1.
- Back-pressure: out_ready=0 with a second OPq offered -> in_ready=0, valE/cc frozen. Release out_ready -> second result appears the next cycle; no results lost or duplicated.
- Stack/memory paths:
  - icode A, valB=64'h100 -> valE=64'hF8.
  - icode B -> valE=64'h108.
  - icode 5, valB=64'h10, valC=64'h8 -> valE=64'h18.
  - cc is unchanged across all three.
- Error case: OPq ifun 7 after a xor giving zero -> out_err=1, valE=0, cc stays 3'b100. Following cmov ifun 3 (e) with valA=5 -> valE=5, cnd=1.
